// File: rtl/id_ex_fwd_stage.sv
// id_ex_fwd_stage
//   ID/EX pipeline register for the 5-stage core.
//   - Captures decoded operands, immediate, destination and control.
//   - Detects load-use hazards: raises stall (combinational) and drops a bubble into EX.
//   - Registers the 2-bit select codes for the two EX operand muxes
//     (00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 immediate on B).
//   - Bypasses the MEM/WB write-back value into the captured operand data
//     when WB writes a register that ID reads in the same cycle.
// Ports
//   CLK, RST               clock / synchronous active-low reset
//   id_*                   decoded instruction currently in ID
//   flush                  kill the ID instruction
//   exmem_*, memwb_*       destinations of the older in-flight instructions
//   stall                  hold PC and IF/ID this cycle
//   ex_*                   registered ID/EX contents and operand mux selects

// Per-operand forwarding lane: select code and WB-bypassed data for one source.
module id_ex_fwd_lane #(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic [RAW-1:0] src,
  input  logic [DW-1:0]  rf_data,
  input  logic           ex_valid,
  input  logic           ex_reg_write,
  input  logic [RAW-1:0] ex_rd,
  input  logic           exmem_reg_write,
  input  logic [RAW-1:0] exmem_rd,
  input  logic           memwb_reg_write,
  input  logic [RAW-1:0] memwb_rd,
  input  logic [DW-1:0]  memwb_wb_data,
  output logic [1:0]     sel,
  output logic [DW-1:0]  data
);
  // A non-zero source is the only way a match can happen, so comparing
  // against src!=0 covers the "rd!=0" condition for every producer.
  logic nz;
  assign nz = (src != '0);

  always_comb begin
    sel = 2'b00;
    // Current EX becomes next EX/MEM: nearest producer, checked first.
    if (nz && ex_valid && ex_reg_write && (ex_rd == src))
      sel = 2'b01;
    else if (nz && exmem_reg_write && (exmem_rd == src))
      sel = 2'b10;
  end

  assign data = (nz && memwb_reg_write && (memwb_rd == src)) ? memwb_wb_data : rf_data;
endmodule

module id_ex_fwd_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH     = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic [DATA_WIDTH-1:0]     id_rs_data,
  input  logic [DATA_WIDTH-1:0]     id_rt_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic                      id_alu_src,
  input  logic                      id_mem_read,
  input  logic                      id_reg_write,
  input  logic [CTRL_WIDTH-1:0]     id_ctrl,
  input  logic                      flush,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_wb_data,
  output logic                      stall,
  output logic                      ex_valid,
  output logic                      ex_mem_read,
  output logic                      ex_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [CTRL_WIDTH-1:0]     ex_ctrl,
  output logic [DATA_WIDTH-1:0]     ex_rs_data,
  output logic [DATA_WIDTH-1:0]     ex_rt_data,
  output logic [DATA_WIDTH-1:0]     ex_imm,
  output logic [1:0]                ex_fwd_a_sel,
  output logic [1:0]                ex_fwd_b_sel
);
  localparam logic [1:0] SEL_IMM = 2'b11;

  // Lane 0 = operand A (rs), lane 1 = operand B (rt).
  logic [1:0][REG_ADDR_WIDTH-1:0] lane_src;
  logic [1:0][DATA_WIDTH-1:0]     lane_rf;
  logic [1:0][1:0]                lane_sel;
  logic [1:0][DATA_WIDTH-1:0]     lane_data;

  assign lane_src = {id_rt, id_rs};
  assign lane_rf  = {id_rt_data, id_rs_data};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    id_ex_fwd_lane #(.DW(DATA_WIDTH), .RAW(REG_ADDR_WIDTH)) u_lane (
      .src             (lane_src[g]),
      .rf_data         (lane_rf[g]),
      .ex_valid        (ex_valid),
      .ex_reg_write    (ex_reg_write),
      .ex_rd           (ex_rd),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_wb_data   (memwb_wb_data),
      .sel             (lane_sel[g]),
      .data            (lane_data[g])
    );
  end

  // Load in EX whose result the ID instruction needs. The bubble clears
  // ex_mem_read, so this can never hold for two cycles in a row.
  assign stall = id_valid & ~flush & ex_valid & ex_mem_read & (ex_rd != '0) &
                 ((id_uses_rs & (ex_rd == id_rs)) | (id_uses_rt & (ex_rd == id_rt)));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ex_valid     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_rd        <= '0;
      ex_ctrl      <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_fwd_a_sel <= 2'b00;
      ex_fwd_b_sel <= 2'b00;
    end else if (flush || stall || !id_valid) begin
      // Bubble: only the qualifiers and selects matter; data regs hold.
      ex_valid     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_fwd_a_sel <= 2'b00;
      ex_fwd_b_sel <= 2'b00;
    end else begin
      ex_valid     <= 1'b1;
      ex_mem_read  <= id_mem_read;
      ex_reg_write <= id_reg_write;
      ex_rd        <= id_rd;
      ex_ctrl      <= id_ctrl;
      ex_rs_data   <= lane_data[0];
      ex_rt_data   <= lane_data[1];
      ex_imm       <= id_imm;
      ex_fwd_a_sel <= lane_sel[0];
      ex_fwd_b_sel <= id_alu_src ? SEL_IMM : lane_sel[1];
    end
  end
endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Bench for id_ex_fwd_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_id_ex_fwd_stage;
  logic        CLK = 1'b0;
  logic        RST;
  logic        id_valid, id_uses_rs, id_uses_rt, id_alu_src, id_mem_read, id_reg_write, flush;
  logic [4:0]  id_rs, id_rt, id_rd, exmem_rd, memwb_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm, memwb_wb_data;
  logic [7:0]  id_ctrl;
  logic        exmem_reg_write, memwb_reg_write;
  logic        stall, ex_valid, ex_mem_read, ex_reg_write;
  logic [4:0]  ex_rd;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [1:0]  ex_fwd_a_sel, ex_fwd_b_sel;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  id_ex_fwd_stage dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .id_ctrl(id_ctrl), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd), .memwb_wb_data(memwb_wb_data), .stall(stall), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_fwd_a_sel(ex_fwd_a_sel), .ex_fwd_b_sel(ex_fwd_b_sel)
  );

  // Model of what EX must hold. m_known: data/ctrl fields are defined
  // (after reset or a capture); during bubbles they are don't-care.
  bit          m_valid, m_mr, m_rw, m_known;
  bit [4:0]    m_rd;
  bit [7:0]    m_ctrl;
  bit [31:0]   m_rs, m_rt, m_imm;
  bit [1:0]    m_sa, m_sb;
  logic        last_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Which mux input holds the freshest value of register r once this ID
  // instruction reaches EX: 1 = the instruction now in EX, 2 = the one now
  // in EX/MEM, 0 = the regfile value (also always for r0).
  function automatic bit [1:0] src_of(input bit [4:0] r);
    if (r == 0) return 2'd0;
    if (m_valid && m_rw && m_rd == r) return 2'd1;
    if (exmem_reg_write && exmem_rd == r) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit [31:0] rd_val(input bit [4:0] r, input bit [31:0] rf);
    return (r != 0 && memwb_reg_write && memwb_rd == r) ? memwb_wb_data : rf;
  endfunction

  function automatic bit need_stall();
    bit uses_load;
    uses_load = (id_uses_rs && id_rs == m_rd) || (id_uses_rt && id_rt == m_rd);
    return id_valid && !flush && m_valid && m_mr && m_rd != 0 && uses_load;
  endfunction

  // One clock: check stall mid-cycle, advance the model across the edge,
  // then check every registered output just after the edge.
  task automatic step();
    bit es;
    @(negedge CLK);
    es = need_stall();
    last_stall = stall;
    chk("stall", stall, 32'(es));
    @(posedge CLK);
    if (!RST) begin
      {m_valid, m_mr, m_rw, m_rd, m_ctrl, m_rs, m_rt, m_imm, m_sa, m_sb} = '0;
      m_known = 1;
    end else if (flush || es || !id_valid) begin
      m_valid = 0; m_mr = 0; m_rw = 0; m_sa = 0; m_sb = 0; m_known = 0;
    end else begin
      m_sa = src_of(id_rs);
      m_sb = id_alu_src ? 2'd3 : src_of(id_rt);
      m_rs = rd_val(id_rs, id_rs_data);
      m_rt = rd_val(id_rt, id_rt_data);
      m_valid = 1; m_mr = id_mem_read; m_rw = id_reg_write; m_rd = id_rd;
      m_ctrl = id_ctrl; m_imm = id_imm; m_known = 1;
    end
    #1;
    chk("ex_valid", ex_valid, 32'(m_valid));
    chk("ex_mem_read", ex_mem_read, 32'(m_mr));
    chk("ex_reg_write", ex_reg_write, 32'(m_rw));
    chk("ex_fwd_a_sel", ex_fwd_a_sel, 32'(m_sa));
    chk("ex_fwd_b_sel", ex_fwd_b_sel, 32'(m_sb));
    if (m_known) begin
      chk("ex_rd", ex_rd, 32'(m_rd));
      chk("ex_ctrl", ex_ctrl, 32'(m_ctrl));
      chk("ex_rs_data", ex_rs_data, m_rs);
      chk("ex_rt_data", ex_rt_data, m_rt);
      chk("ex_imm", ex_imm, m_imm);
    end
  endtask

  task automatic clr();
    RST = 1; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_rs_data = 32'h1111_0000; id_rt_data = 32'h2222_0000; id_imm = 32'h0000_0042;
    id_alu_src = 0; id_mem_read = 0; id_reg_write = 0; id_ctrl = 8'h00; flush = 0;
    exmem_reg_write = 0; exmem_rd = 0; memwb_reg_write = 0; memwb_rd = 0;
    memwb_wb_data = 32'h0;
  endtask

  task automatic rnd();
    RST = ($urandom_range(63) != 0);
    id_valid = ($urandom_range(7) != 0);
    id_rs = 5'($urandom_range(3)); id_rt = 5'($urandom_range(3)); id_rd = 5'($urandom_range(3));
    id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_alu_src = ($urandom_range(3) == 0); id_mem_read = ($urandom_range(2) == 0);
    id_reg_write = 1'($urandom); id_ctrl = 8'($urandom);
    flush = ($urandom_range(7) == 0);
    exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(3));
    memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(3));
    memwb_wb_data = $urandom;
  endtask

  initial begin
    clr();
    // Reset state
    RST = 0; step();
    chk("rst_valid", ex_valid, 0); chk("rst_sel_a", ex_fwd_a_sel, 0);
    chk("rst_sel_b", ex_fwd_b_sel, 0); chk("rst_rs_data", ex_rs_data, 0);
    // add r3 in EX, sub reads r3 -> sel_a 01
    clr(); id_valid = 1; id_rd = 3; id_reg_write = 1; id_rs = 1; id_rt = 2; step();
    clr(); id_valid = 1; id_rs = 3; id_uses_rs = 1; id_rt = 2; id_rd = 6; id_reg_write = 1; step();
    chk("fwd_ex_stall", last_stall, 0); chk("fwd_ex_sel_a", ex_fwd_a_sel, 2'b01);
    // lw r5 then add reading rt=5 -> one stall + bubble, then sel_b 10
    clr(); id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5; id_rs = 1; step();
    clr(); id_valid = 1; id_rs = 1; id_uses_rs = 1; id_rt = 5; id_uses_rt = 1; id_rd = 8;
    id_reg_write = 1; step();
    chk("lu_stall", last_stall, 1); chk("lu_bubble", ex_valid, 0);
    exmem_reg_write = 1; exmem_rd = 5; step();
    chk("lu_stall2", last_stall, 0); chk("lu_valid", ex_valid, 1);
    chk("lu_sel_b", ex_fwd_b_sel, 2'b10);
    // EX and EX/MEM both write r4 -> nearest (EX) wins
    clr(); id_valid = 1; id_rd = 4; id_reg_write = 1; step();
    clr(); id_valid = 1; id_rs = 4; id_uses_rs = 1; exmem_reg_write = 1; exmem_rd = 4; step();
    chk("nearest_sel_a", ex_fwd_a_sel, 2'b01);
    // WB bypass of r7
    clr(); step();
    clr(); id_valid = 1; id_rs = 7; id_uses_rs = 1; id_rs_data = 32'h0;
    memwb_reg_write = 1; memwb_rd = 7; memwb_wb_data = 32'hDEADBEEF; step();
    chk("wb_byp_data", ex_rs_data, 32'hDEADBEEF); chk("wb_byp_sel_a", ex_fwd_a_sel, 2'b00);
    // r0 never forwarded; alu_src forces 11
    clr(); id_valid = 1; id_reg_write = 1; id_rd = 0; step();
    clr(); id_valid = 1; id_alu_src = 1; exmem_reg_write = 1; memwb_reg_write = 1;
    memwb_wb_data = 32'h5555_5555; step();
    chk("r0_sel_a", ex_fwd_a_sel, 2'b00); chk("imm_sel_b", ex_fwd_b_sel, 2'b11);
    chk("r0_no_byp", ex_rs_data, 32'h1111_0000);
    // flush with pending load-use: no stall, bubble
    clr(); id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5; step();
    clr(); id_valid = 1; id_rs = 5; id_uses_rs = 1; flush = 1; step();
    chk("flush_stall", last_stall, 0); chk("flush_bubble", ex_valid, 0);
    // reset mid-stream, with a load in EX
    clr(); id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 9; id_ctrl = 8'hA5; step();
    clr(); id_valid = 1; id_rs = 9; id_uses_rs = 1; RST = 0; step();
    chk("mid_rst_valid", ex_valid, 0); chk("mid_rst_ctrl", ex_ctrl, 0);
    chk("mid_rst_rd", ex_rd, 0); chk("mid_rst_sel_b", ex_fwd_b_sel, 0);
    RST = 1; step();
    chk("post_rst_stall", last_stall, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rnd();
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
